// File: rtl/tdm_demux_4ch.sv
// Four-slot TDM demultiplexer: locks onto a sync-marked slot-0 word, collects
// slots 0..3, and presents each complete frame on y0..y3 with a one-cycle strobe.
module tdm_demux_4ch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         out_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   frame_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t       r_state, w_state_nx;
  logic [1:0]   r_slot, w_slot_nx;
  logic [W-1:0] r_buf0, r_buf1, r_buf2;
  logic [W-1:0] w_buf0_nx, w_buf1_nx, w_buf2_nx;
  logic [W-1:0] r_y0, r_y1, r_y2, r_y3;
  logic [W-1:0] w_y0_nx, w_y1_nx, w_y2_nx, w_y3_nx;
  logic         r_out_valid, w_out_valid_nx;
  logic         r_sync_err, w_sync_err_nx;
  logic [7:0]   r_frame_cnt, w_frame_cnt_nx;

  // NOTE: every register uses <= so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_slot      <= 2'd0;
      // NOTE: slot buffers are cleared too, so a stale partial frame can never leak out.
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_buf2      <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_y3        <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nx;
      r_slot      <= w_slot_nx;
      r_buf0      <= w_buf0_nx;
      r_buf1      <= w_buf1_nx;
      r_buf2      <= w_buf2_nx;
      r_y0        <= w_y0_nx;
      r_y1        <= w_y1_nx;
      r_y2        <= w_y2_nx;
      r_y3        <= w_y3_nx;
      r_out_valid <= w_out_valid_nx;
      r_sync_err  <= w_sync_err_nx;
      r_frame_cnt <= w_frame_cnt_nx;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first keep this block free of latches.
    w_state_nx     = r_state;
    w_slot_nx      = r_slot;
    w_buf0_nx      = r_buf0;
    w_buf1_nx      = r_buf1;
    w_buf2_nx      = r_buf2;
    w_y0_nx        = r_y0;
    w_y1_nx        = r_y1;
    w_y2_nx        = r_y2;
    w_y3_nx        = r_y3;
    w_out_valid_nx = 1'b0;
    w_sync_err_nx  = 1'b0;
    w_frame_cnt_nx = r_frame_cnt;

    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_buf0_nx  = din;
            w_slot_nx  = 2'd1;
            w_state_nx = LOCKED;
          end
        end
        default: begin
          if (sync) begin
            // A sync mid-frame restarts the frame; the earlier slots are simply overwritten.
            w_sync_err_nx = (r_slot != 2'd0);
            w_buf0_nx     = din;
            w_slot_nx     = 2'd1;
          end else begin
            case (r_slot)
              2'd0: begin
                w_sync_err_nx = 1'b1;
                w_state_nx    = HUNT;
              end
              2'd1: begin
                w_buf1_nx = din;
                w_slot_nx = 2'd2;
              end
              2'd2: begin
                w_buf2_nx = din;
                w_slot_nx = 2'd3;
              end
              default: begin
                w_y0_nx        = r_buf0;
                w_y1_nx        = r_buf1;
                w_y2_nx        = r_buf2;
                w_y3_nx        = din;
                w_out_valid_nx = 1'b1;
                w_frame_cnt_nx = r_frame_cnt + 8'd1;
                w_slot_nx      = 2'd0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign y0        = r_y0;
  assign y1        = r_y1;
  assign y2        = r_y2;
  assign y3        = r_y3;
  assign out_valid = r_out_valid;
  assign sync_err  = r_sync_err;
  assign frame_cnt = r_frame_cnt;
  assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: expected frames are queued as stimulus
// is driven and popped/compared whenever the DUT strobes out_valid.
module tb_tdm_demux_4ch;

  localparam int W = 8;

  bit          clk = 1'b0;
  logic        rst;
  logic [W-1:0] din;
  logic        din_valid;
  logic        sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic        out_valid;
  logic        locked;
  logic        sync_err;
  logic [7:0]  frame_cnt;

  tdm_demux_4ch #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [7:0]  fc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          n_ov  = 0;
  int          n_se  = 0;
  logic [7:0]  exp_fc = 8'd0;
  logic        rst_q  = 1'b1;
  logic [31:0] prev_y = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Scoreboard consumer and per-cycle invariants.
  always @(negedge clk) begin
    exp_t e;
    check("ov_se_excl", {31'd0, out_valid & sync_err}, 32'd0);
    if (sync_err === 1'b1) n_se++;
    if (out_valid === 1'b1) begin
      n_ov++;
      if (sb.size() == 0) begin
        check("spurious_ov", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_y",   {y0, y1, y2, y3}, e.y);
        check("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.fc});
        check("latency",   cyc, e.cyc);
      end
      prev_y = {y0, y1, y2, y3};
    end else if (rst_q) begin
      prev_y = {y0, y1, y2, y3};
    end else begin
      check("y_hold", {y0, y1, y2, y3}, prev_y);
    end
  end

  task automatic word(input logic [7:0] d, input logic s);
    din       = d;
    sync      = s;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge that presents the slot-3 word; it is accepted at the next posedge.
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    exp_t e;
    exp_fc = exp_fc + 8'd1;
    e.y    = {a, b, c, d};
    e.fc   = exp_fc;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst    = 1'b0;
    exp_fc = 8'd0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_y"},      {y0, y1, y2, y3}, 32'd0);
    check({tag, "_ov"},     {31'd0, out_valid}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_serr"},   {31'd0, sync_err}, 32'd0);
    check({tag, "_fcnt"},   {24'd0, frame_cnt}, 32'd0);
  endtask

  initial begin
    int ov0, se0;
    logic [7:0] d0, d1, d2, d3;
    rst = 1'b1; din = '0; sync = 1'b0; din_valid = 1'b0;

    // Reset state
    idle(2);
    check_idle_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Nominal frame
    word(8'h11, 1'b1); word(8'h22, 1'b0); word(8'h33, 1'b0);
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
    word(8'h44, 1'b0);
    check("nom_locked", {31'd0, locked}, 32'd1);
    check("nom_fcnt",   {24'd0, frame_cnt}, 32'd1);
    idle(1);
    check("nom_ov_drop", {31'd0, out_valid}, 32'd0);
    idle(1);

    // Gapped input
    do_reset(1);
    ov0 = n_ov;
    word(8'h11, 1'b1); idle(3);
    word(8'h22, 1'b0); idle(3);
    word(8'h33, 1'b0); idle(3);
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
    word(8'h44, 1'b0);
    idle(2);
    check("gap_fcnt",  {24'd0, frame_cnt}, 32'd1);
    check("gap_ov_n",  n_ov - ov0, 32'd1);

    // Early sync
    do_reset(1);
    ov0 = n_ov; se0 = n_se;
    word(8'hA0, 1'b1); word(8'hA1, 1'b0);
    word(8'hB0, 1'b1);
    check("early_serr",   {31'd0, sync_err}, 32'd1);
    check("early_locked", {31'd0, locked}, 32'd1);
    word(8'hB1, 1'b0); word(8'hB2, 1'b0);
    expect_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    word(8'hB3, 1'b0);
    idle(2);
    check("early_se_n", n_se - se0, 32'd1);
    check("early_ov_n", n_ov - ov0, 32'd1);

    // Missing sync after a good frame
    ov0 = n_ov; se0 = n_se;
    word(8'h55, 1'b0);
    check("miss_serr",   {31'd0, sync_err}, 32'd1);
    check("miss_locked", {31'd0, locked}, 32'd0);
    word(8'h56, 1'b0); word(8'h57, 1'b0); word(8'h58, 1'b0);
    idle(2);
    check("miss_ov_n",   n_ov - ov0, 32'd0);
    check("miss_se_n",   n_se - se0, 32'd1);
    check("miss_y",      {y0, y1, y2, y3}, 32'hB0B1B2B3);
    check("miss_locked2", {31'd0, locked}, 32'd0);

    // Reset mid-frame, with a valid sync word presented during reset
    ov0 = n_ov;
    word(8'h01, 1'b1); word(8'h02, 1'b0);
    rst = 1'b1; din = 8'hFF; sync = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0; exp_fc = 8'd0;
    check("rstpri_locked", {31'd0, locked}, 32'd0);
    word(8'h03, 1'b0); word(8'h04, 1'b0);
    idle(2);
    check("rstmid_ov_n", n_ov - ov0, 32'd0);
    check_idle_outputs("rstmid");

    // 256 back-to-back frames; frame_cnt wraps to 0
    ov0 = n_ov; se0 = n_se;
    for (int f = 0; f < 256; f++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      word(d0, 1'b1); word(d1, 1'b0); word(d2, 1'b0);
      expect_frame(d0, d1, d2, d3);
      word(d3, 1'b0);
    end
    idle(2);
    check("b2b_fcnt_wrap", {24'd0, frame_cnt}, 32'd0);
    check("b2b_ov_n",      n_ov - ov0, 32'd256);
    check("b2b_se_n",      n_se - se0, 32'd0);
    check("b2b_locked",    {31'd0, locked}, 32'd1);
    check("sb_drained",    sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
